audio_frame_sync: RTL

AUDIO_FRAME_SYNC -- requirements
Module: audio_frame_sync

---
 rtl/audio_frame_sync.sv | 130 +++++++++++++
 1 files changed

// File: rtl/audio_frame_sync.sv
// audio_frame_sync: finds and validates MPEG audio frame headers, then hands the bit stream to the decoder.
// Optional AUDIO_CRC_SKIP_EN: consume the 16-bit CRC after protected headers before handing over.
module audio_frame_sync (
  input  logic        resetn,
  input  logic        audio_clock,
  input  logic        Start_I,
  input  logic        Flush_I,
  input  logic [15:0] Bs_Data_I,
  input  logic        Bs_Empty_I,
  input  logic        Bs_Busy_I,
  input  logic        Bs_Byte_Allign_I,
  output logic [4:0]  Bs_Shift_En_O,
  input  logic [4:0]  Dec_Shift_En_I,
  input  logic        Frame_Done_I,
  output logic [19:0] Header_O,
  output logic        Header_Valid_O,
  output logic        Crc_Present_O,
  output logic [7:0]  Resync_Count_O,
  output logic        In_Pass_O
);
  typedef enum logic [2:0] {IDLE, PRIME, SEARCH, HDR_HI, HDR_LO, CRC, PASS} state_t;
  state_t state, state_n;
  logic [2:0] left, left_n;
  logic settle, settle_n;
  logic [19:0] hdr, hdr_n, header_n;
  logic valid_n, crc_n, can, sh1, sh8, bad;
  logic [7:0] resync_n;
  assign can = !Bs_Empty_I && !Bs_Busy_I;
  assign bad = hdr[18:17] == 2'b00 || hdr[15:12] == 4'hF || hdr[11:10] == 2'b11;
  assign In_Pass_O = state == PASS;
  assign Bs_Shift_En_O = Flush_I ? 5'd0 : In_Pass_O ? Dec_Shift_En_I : {3'd0, sh8, sh1};
  // Pending byte shifts (left) and the settle cycle are drained before any state evaluates its data.
  always_comb begin
    state_n = state;
    left_n = left;
    settle_n = 1'b0;
    hdr_n = hdr;
    header_n = Header_O;
    valid_n = 1'b0;
    crc_n = Crc_Present_O;
    resync_n = Resync_Count_O;
    sh1 = 1'b0;
    sh8 = 1'b0;
    if (Flush_I) begin
      state_n = IDLE;
      left_n = 3'd0;
      hdr_n = 20'd0;
      header_n = 20'd0;
      crc_n = 1'b0;
    end else if (!settle) begin
      if (left != 3'd0) begin
        sh8 = can;
        left_n = left - {2'd0, can};
      end else begin
        case (state)
          IDLE: begin
            state_n = Start_I ? PRIME : IDLE;
            left_n = Start_I ? 3'd4 : 3'd0;
          end
          PRIME: state_n = SEARCH;
          SEARCH: if (can) begin
            sh1 = !Bs_Byte_Allign_I;
            sh8 = Bs_Byte_Allign_I;
            if (Bs_Byte_Allign_I && Bs_Data_I[15:4] == 12'hFFF) begin
              hdr_n[19:16] = Bs_Data_I[3:0];
              left_n = 3'd1;
              state_n = HDR_HI;
            end
          end
          HDR_HI: if (can) begin
            hdr_n[15:0] = Bs_Data_I;
            sh8 = 1'b1;
            left_n = 3'd1;
            state_n = HDR_LO;
          end
          HDR_LO: if (bad) begin
            state_n = SEARCH;
            resync_n = Resync_Count_O + {7'd0, Resync_Count_O != 8'hFF};
          end
`ifdef AUDIO_CRC_SKIP_EN
          else if (!hdr[16]) begin
            state_n = CRC;
            left_n = 3'd2;
          end
`endif
          else begin
            state_n = PASS;
            valid_n = 1'b1;
            header_n = hdr;
            crc_n = !hdr[16];
          end
`ifdef AUDIO_CRC_SKIP_EN
          CRC: begin
            state_n = PASS;
            valid_n = 1'b1;
            header_n = hdr;
            crc_n = !hdr[16];
          end
`endif
          PASS: begin
            state_n = Frame_Done_I ? SEARCH : PASS;
            settle_n = Frame_Done_I;
          end
          default: state_n = IDLE;
        endcase
      end
    end
    if (sh1 || sh8) settle_n = 1'b1;
  end
  always_ff @(posedge audio_clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      left <= 3'd0;
      settle <= 1'b0;
      hdr <= 20'd0;
      Header_O <= 20'd0;
      Header_Valid_O <= 1'b0;
      Crc_Present_O <= 1'b0;
      Resync_Count_O <= 8'd0;
    end else begin
      state <= state_n;
      left <= left_n;
      settle <= settle_n;
      hdr <= hdr_n;
      Header_O <= header_n;
      Header_Valid_O <= valid_n;
      Crc_Present_O <= crc_n;
      Resync_Count_O <= resync_n;
    end
endmodule
